// File: rtl/cpu_bank_reg_pkg.sv
// cpu_bank_reg_pkg: types and helpers shared by the multi-port register bank.
//   reg_addr_t / reg_data_t : address and data types at the default bank size
//   ZERO_REG_IDX            : index of the optional hardwired-zero register
//   resolve_write()         : picks the winning write port among those that hit
`ifndef NUM_REGS
`define NUM_REGS 16
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package cpu_bank_reg_pkg;

  localparam int DEF_NUM_REGS  = `NUM_REGS;
  localparam int DEF_REG_WIDTH = `REG_WIDTH;
  localparam int ZERO_REG_IDX  = 0;
  localparam int MAX_WRITE     = 2;

  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [DEF_REG_WIDTH-1:0]        reg_data_t;

  // Result of write-port arbitration for one target register.
  typedef struct packed {
    logic       hit;   // at least one enabled port targets the register
    logic [0:0] port;  // winning port index when hit is set
  } wr_sel_t;

  // Highest-indexed hitting port wins, so later ports override earlier ones.
  function automatic wr_sel_t resolve_write(input logic [MAX_WRITE-1:0] hits);
    wr_sel_t sel;
    sel.hit  = |hits;
    sel.port = 1'b0;
    for (int p = 0; p < MAX_WRITE; p++) begin
      if (hits[p]) sel.port = 1'(p);
    end
    return sel;
  endfunction

endpackage

// File: rtl/cpu_bank_reg_scoreboard.sv
// cpu_bank_reg_scoreboard: busy-bit scoreboard for the register bank.
//   clk, rst_n    : clock, asynchronous active-low reset
//   read_reg      : NUM_READ packed read addresses
//   write_enable  : per-write-port strobe (a write releases its register)
//   write_reg     : NUM_WRITE packed write addresses
//   reserve_en    : mark reserve_reg busy at the edge
//   reserve_reg   : register being reserved by decode
//   read_busy     : per read port, addressed register still has a producer
module cpu_bank_reg_scoreboard
  import cpu_bank_reg_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int ZERO_REG  = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_READ*AW-1:0]  read_reg,
  input  logic [NUM_WRITE-1:0]    write_enable,
  input  logic [NUM_WRITE*AW-1:0] write_reg,
  input  logic                    reserve_en,
  input  logic [AW-1:0]           reserve_reg,
  output logic [NUM_READ-1:0]     read_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] release_vec;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    release_vec = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (write_enable[p]) release_vec[write_reg[p*AW +: AW]] = 1'b1;
    end
  end

  // Release first, then reserve: a same-cycle reserve is the newer producer.
  always_comb begin
    busy_d = busy_q & ~release_vec;
    if (reserve_en) busy_d[reserve_reg] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_REG_IDX] = 1'b0;
  end

  // NOTE: state flops use non-blocking assignment so all flops sample
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A same-cycle write satisfies the read through the bypass, so no stall.
  always_comb begin
    read_busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      read_busy[i] = busy_q[read_reg[i*AW +: AW]] & ~release_vec[read_reg[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/cpu_bank_reg_mp.sv
// cpu_bank_reg_mp: multi-port CPU register bank with write-to-read bypass,
// optional hardwired zero register, busy scoreboard and optional read register.
//   clk, rst_n    : clock, asynchronous active-low reset
//   read_reg      : NUM_READ packed read addresses
//   read_data     : NUM_READ packed read data
//   read_busy     : per read port, addressed register has a pending producer
//   write_enable  : per-write-port strobe
//   write_reg     : NUM_WRITE packed write addresses
//   write_data    : NUM_WRITE packed write data
//   reserve_en    : reserve reserve_reg (mark busy) at the edge
//   reserve_reg   : register to reserve
module cpu_bank_reg_mp
  import cpu_bank_reg_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int REG_WIDTH    = 32,
  parameter int NUM_READ     = 2,
  parameter int NUM_WRITE    = 1,
  parameter int ZERO_REG     = 1,
  parameter int READ_LATENCY = 0,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*AW-1:0]         read_reg,
  output logic [NUM_READ*REG_WIDTH-1:0]  read_data,
  output logic [NUM_READ-1:0]            read_busy,
  input  logic [NUM_WRITE-1:0]           write_enable,
  input  logic [NUM_WRITE*AW-1:0]        write_reg,
  input  logic [NUM_WRITE*REG_WIDTH-1:0] write_data,
  input  logic                           reserve_en,
  input  logic [AW-1:0]                  reserve_reg
);

  logic [REG_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [REG_WIDTH-1:0]          regs_d [NUM_REGS];
  logic [NUM_READ*REG_WIDTH-1:0] rd_data_c;
  logic [NUM_READ-1:0]           rd_busy_c;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(ZERO_REG_IDX));
  endfunction

  // Arbitrate the write ports targeting address a.
  function automatic wr_sel_t match(input logic [AW-1:0] a);
    logic [MAX_WRITE-1:0] hits;
    hits = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      hits[p] = write_enable[p] && (write_reg[p*AW +: AW] == a);
    end
    return resolve_write(hits);
  endfunction

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin : g_wr
      wr_sel_t sel;
      sel       = match(AW'(r));
      regs_d[r] = regs_q[r];
      if (sel.hit && !is_zero(AW'(r))) begin
        regs_d[r] = write_data[int'(sel.port)*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // NOTE: the array is plain flops (no RAM), so it takes the reset like any
  // other state; RAM-style storage could not be cleared this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  // Bypass: an enabled write this cycle overrides the stored value.
  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_READ; i++) begin : g_rd
      logic [AW-1:0] a;
      wr_sel_t       sel;
      a   = read_reg[i*AW +: AW];
      sel = match(a);
      if (is_zero(a)) begin
        rd_data_c[i*REG_WIDTH +: REG_WIDTH] = '0;
      end else if (sel.hit) begin
        rd_data_c[i*REG_WIDTH +: REG_WIDTH] = write_data[int'(sel.port)*REG_WIDTH +: REG_WIDTH];
      end else begin
        rd_data_c[i*REG_WIDTH +: REG_WIDTH] = regs_q[a];
      end
    end
  end

  cpu_bank_reg_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_reg     (read_reg),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .reserve_en   (reserve_en),
    .reserve_reg  (reserve_reg),
    .read_busy    (rd_busy_c)
  );

  if (READ_LATENCY == 0) begin : g_comb_rd
    assign read_data = rd_data_c;
    assign read_busy = rd_busy_c;
  end else begin : g_reg_rd
    // Registering the bypassed value captures writes from the cycle before the edge.
    logic [NUM_READ*REG_WIDTH-1:0] rd_data_q;
    logic [NUM_READ-1:0]           rd_busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        rd_data_q <= rd_data_c;
        rd_busy_q <= rd_busy_c;
      end
    end
    assign read_data = rd_data_q;
    assign read_busy = rd_busy_q;
  end

endmodule
